core_memory_responder: RTL and testbench



---
 rtl/core_memory_responder_pkg.sv | 14 +
 rtl/core_memory_array.sv | 35 +++
 rtl/core_memory_responder.sv | 115 +++++++++++
 tb/tb_core_memory_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_memory_responder_pkg.sv
// Shared constants and FSM encoding for the core memory responder.
// Aligned with the core's 5-bit memory address.
package core_memory_responder_pkg;

  localparam int MEM_DEPTH      = 32;
  localparam int MEM_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/core_memory_array.sv
// Word store: async read port, sync write port, sync clear.
// Clear has priority over the write port.
module core_memory_array
  import core_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DEPTH      = MEM_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Zero-latency read; old word is visible until the write edge.
  assign rdata_o = mem_q[raddr_i];

  // Storage update: clear wipes everything, otherwise single write.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/core_memory_responder.sv
// Memory responder: program loader, core memory port, halt tracking.
// Optional macro PROGRAM_PROTECT_EN drops core writes into the program.
module core_memory_responder
  import core_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DEPTH      = MEM_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  halted,
  output logic                  start_execution,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  write_fault
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR =
    ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  fault_q, fault_d;

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  accept;
  logic                  prot_hit;

  core_memory_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk_i  (clock),
    .clear_i(reset),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .raddr_i(mem_addr),
    .rdata_o(mem_read_data)
  );

  // State-derived outputs change only at the clock edge.
  assign load_ready      = (state_q == ST_LOAD);
  assign start_execution = (state_q != ST_LOAD);
  assign done            = (state_q == ST_HALTED);
  assign word_count      = count_q;
  assign write_fault     = fault_q;
  assign accept          = load_ready & load_valid;

  // Next state, write-port mux and protection check.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    fault_d = fault_q;
    we      = 1'b0;
    waddr   = ptr_q;
    wdata   = load_data;
`ifdef PROGRAM_PROTECT_EN
    prot_hit = ({1'b0, mem_addr} < count_q);
`else
    prot_hit = 1'b0;
`endif
    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          we      = 1'b1;
          count_d = count_q + 1'b1;
          if (ptr_q != LAST_PTR) ptr_d = ptr_q + 1'b1;
          if (load_last || ptr_q == LAST_PTR) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        waddr = mem_addr;
        wdata = mem_write_data;
        if (mem_write) begin
          if (prot_hit) fault_d = 1'b1;
          else          we      = 1'b1;
        end
        if (halted) state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_LOAD;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_LOAD;
      ptr_q   <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_core_memory_responder.sv
// Self-checking bench for core_memory_responder.
// Directed scenarios plus randomized traffic against a word-level model.
module tb_core_memory_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic [4:0]  mem_addr = '0;
  logic [15:0] mem_write_data = '0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_read_data;
  logic        halted = 1'b0;
  logic        start_execution;
  logic        done;
  logic [5:0]  word_count;
  logic        write_fault;

  int total = 0;
  int bad = 0;

  core_memory_responder dut (
    .clock          (clock),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_last      (load_last),
    .load_ready     (load_ready),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .halted         (halted),
    .start_execution(start_execution),
    .done           (done),
    .word_count     (word_count),
    .write_fault    (write_fault)
  );

  always #5 clock = ~clock;

  // Word-level model: memory image, words loaded, loaded/halted flags.
  logic [15:0] m_mem [32];
  int          m_cnt = 0;
  bit          m_loaded = 0;
  bit          m_halt = 0;
  bit          m_fault = 0;
  bit          m_valid = 0;

  always @(posedge clock) begin
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_cnt = 0; m_loaded = 0; m_halt = 0;
      m_fault = 0; m_valid = 1;
    end else if (!m_loaded) begin
      if (load_valid) begin
        m_mem[m_cnt] = load_data;
        m_cnt++;
        if (load_last || m_cnt == 32) m_loaded = 1;
      end
    end else if (!m_halt) begin
      if (mem_write) begin
`ifdef PROGRAM_PROTECT_EN
        if (int'(mem_addr) < m_cnt) m_fault = 1;
        else m_mem[mem_addr] = mem_write_data;
`else
        m_mem[mem_addr] = mem_write_data;
`endif
      end
      if (halted) m_halt = 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the edge.
  always @(negedge clock) begin
    if (m_valid && !reset) begin
      check("rdata", 32'(mem_read_data), 32'(m_mem[mem_addr]));
      check("ready", 32'(load_ready), 32'(!m_loaded));
      check("start", 32'(start_execution), 32'(m_loaded));
      check("done", 32'(done), 32'(m_halt));
      check("count", 32'(word_count), 32'(m_cnt));
      check("fault", 32'(write_fault), 32'(m_fault));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    load_valid = 0; load_last = 0; mem_write = 0; halted = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic push(input logic [15:0] d, input bit last);
    load_valid = 1; load_data = d; load_last = last;
    step();
    load_valid = 0; load_last = 0;
  endtask

  task automatic peek(input string nm, input logic [4:0] a,
                      input logic [15:0] exp);
    mem_addr = a;
    #1;
    check(nm, 32'(mem_read_data), 32'(exp));
  endtask

  initial begin
    do_reset();
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_start", 32'(start_execution), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Three words, last on the third.
    push(16'h1234, 0);
    push(16'h5678, 0);
    check("t1_nostart", 32'(start_execution), 32'd0);
    push(16'h0000, 1);
    check("t1_count", 32'(word_count), 32'd3);
    check("t1_start", 32'(start_execution), 32'd1);
    check("t1_ready", 32'(load_ready), 32'd0);
    peek("t1_rd1", 5'd1, 16'h5678);

    // Core write into free space.
    mem_addr = 5'd20; mem_write_data = 16'h00FF; mem_write = 1;
    step();
    mem_write = 0;
    peek("t4_rd20", 5'd20, 16'h00FF);

    // Write into the loaded program region.
    mem_addr = 5'd2; mem_write_data = 16'hDEAD; mem_write = 1;
    step();
    mem_write = 0;
    step();
`ifdef PROGRAM_PROTECT_EN
    peek("t4_prot", 5'd2, 16'h0000);
    check("t4_fault", 32'(write_fault), 32'd1);
`else
    peek("t4_prot", 5'd2, 16'hDEAD);
    check("t4_fault", 32'(write_fault), 32'd0);
`endif

    // Halt, then a write that must be ignored.
    halted = 1;
    step();
    halted = 0;
    check("t5_done", 32'(done), 32'd1);
    mem_addr = 5'd21; mem_write_data = 16'h1111; mem_write = 1;
    step(); step();
    mem_write = 0;
    peek("t5_rd21", 5'd21, 16'h0000);
    check("t5_start", 32'(start_execution), 32'd1);

    // Gap in the load stream.
    do_reset();
    push(16'hAAAA, 0);
    load_data = 16'h5555;
    step();
    push(16'hBBBB, 1);
    check("t2_count", 32'(word_count), 32'd2);
    peek("t2_rd0", 5'd0, 16'hAAAA);
    peek("t2_rd1", 5'd1, 16'hBBBB);
    peek("t2_rd2", 5'd2, 16'h0000);

    // Implicit last after 32 words.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      check("t3_pre", 32'(start_execution), 32'd0);
      push(16'(16'h0100 + i), 0);
    end
    check("t3_count", 32'(word_count), 32'd32);
    check("t3_ready", 32'(load_ready), 32'd0);
    push(16'hFFFF, 0);
    check("t3_count2", 32'(word_count), 32'd32);
    peek("t3_rd31", 5'd31, 16'h011F);
    peek("t3_rd0", 5'd0, 16'h0100);

    // Reset in the middle of a load.
    do_reset();
    push(16'hCAFE, 0);
    push(16'hBEEF, 0);
    reset = 1;
    step();
    reset = 0;
    check("t6_count", 32'(word_count), 32'd0);
    check("t6_ready", 32'(load_ready), 32'd1);
    peek("t6_rd0", 5'd0, 16'h0000);
    peek("t6_rd1", 5'd1, 16'h0000);

    // Randomized traffic; the negedge compare does the checking.
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(99) == 0);
      load_valid     = ($urandom_range(9) < 6);
      load_data      = 16'($urandom);
      load_last      = ($urandom_range(9) == 0);
      mem_addr       = 5'($urandom);
      mem_write_data = 16'($urandom);
      mem_write      = ($urandom_range(2) == 0);
      halted         = ($urandom_range(24) == 0);
      step();
    end
    idle();
    reset = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
